// File: rtl/mix_update_param_pkg.sv
// mix_update_param_pkg: shared sizes, layer codes and address helpers for the mixing-layer SGD step
package mix_update_param_pkg;
  localparam int HID_DIM    = 16;
  localparam int DATA_N     = 4;
  localparam int N_LEN      = 16;
  localparam int N_LEN_W    = 24;
  localparam int F_LEN      = 8;
  localparam int STATE_LEN  = 3;
  localparam int ADDR_WIDTH = 9;
  localparam int W = HID_DIM * HID_DIM / DATA_N;
  localparam int B = HID_DIM;
  localparam logic [STATE_LEN-1:0] U_MIX1 = 3'd4;
  localparam logic [STATE_LEN-1:0] U_MIX2 = 3'd5;
  localparam logic [STATE_LEN-1:0] U_MIX3 = 3'd6;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  function automatic logic state_ok(input logic [STATE_LEN-1:0] s);
    return s == U_MIX1 || s == U_MIX2 || s == U_MIX3;
  endfunction
  function automatic addr_t base_addr(input logic [STATE_LEN-1:0] s, input int size);
    return s == U_MIX2 ? addr_t'(size) : s == U_MIX3 ? addr_t'(2 * size) : '0;
  endfunction
endpackage

// File: rtl/mix_update_param_if.sv
// mix_update_param_if: gradient and parameter RAM ports seen by the update block
interface mix_update_param_if;
  import mix_update_param_pkg::*;
  logic [ADDR_WIDTH-1:0]     raddr_grad_w, raddr_grad_b, waddr_grad_w, waddr_grad_b;
  logic [ADDR_WIDTH-1:0]     raddr_param_w, raddr_param_b, waddr_param_w, waddr_param_b;
  logic                      we_grad_w, we_grad_b, we_param_w, we_param_b;
  logic [DATA_N*N_LEN_W-1:0] rdata_grad_w;
  logic [N_LEN_W-1:0]        rdata_grad_b;
  logic [DATA_N*N_LEN-1:0]   rdata_param_w, wdata_param_w;
  logic [N_LEN-1:0]          rdata_param_b, wdata_param_b;
  modport master (
    output raddr_grad_w, raddr_grad_b, waddr_grad_w, waddr_grad_b,
    output raddr_param_w, raddr_param_b, waddr_param_w, waddr_param_b,
    output we_grad_w, we_grad_b, we_param_w, we_param_b, wdata_param_w, wdata_param_b,
    input  rdata_grad_w, rdata_grad_b, rdata_param_w, rdata_param_b
  );
  modport slave (
    input  raddr_grad_w, raddr_grad_b, waddr_grad_w, waddr_grad_b,
    input  raddr_param_w, raddr_param_b, waddr_param_w, waddr_param_b,
    input  we_grad_w, we_grad_b, we_param_w, we_param_b, wdata_param_w, wdata_param_b,
    output rdata_grad_w, rdata_grad_b, rdata_param_w, rdata_param_b
  );
endinterface

// File: rtl/mix_update_lane.sv
// mix_update_lane: one lane of w - floor(lr*g >> F_LEN), saturated to the parameter width
module mix_update_lane
  import mix_update_param_pkg::*;
(
  input  logic signed [N_LEN-1:0]   lr_i,
  input  logic signed [N_LEN_W-1:0] g_i,
  input  logic signed [N_LEN-1:0]   w_i,
  output logic signed [N_LEN-1:0]   w_o
);
  localparam int PW = N_LEN + N_LEN_W;
  localparam logic signed [N_LEN_W:0] D_MAX = (N_LEN_W + 1)'(2 ** (N_LEN - 1) - 1);
  localparam logic signed [N_LEN_W:0] D_MIN = ~D_MAX;
  logic signed [PW-1:0]      p;
  logic signed [N_LEN_W-1:0] s;
  logic signed [N_LEN_W:0]   d;
  // full-width product, floor shift, widened subtract, clamp
  always_comb begin
    p   = PW'(lr_i) * PW'(g_i);
    s   = N_LEN_W'(p >>> F_LEN);
    d   = (N_LEN_W + 1)'(w_i) - (N_LEN_W + 1)'(s);
    w_o = d > D_MAX ? N_LEN'(D_MAX) : d < D_MIN ? N_LEN'(D_MIN) : N_LEN'(d);
  end
endmodule

// File: rtl/mix_update_param.sv
// mix_update_param: streams grad/param RAMs of one mixing layer, writes SGD result and clears grads
module mix_update_param
  import mix_update_param_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_i,
  input  logic [STATE_LEN-1:0] state_i,
  input  logic [N_LEN-1:0]     lr_i,
  output logic                 valid_o,
  mix_update_param_if.master   ram
);
  localparam int CW_W = $clog2(W + 1);
  localparam int CW_B = $clog2(B + 1);
  logic                       ok;
  addr_t                      base_w, base_b, last_w, last_b;
  logic [CW_W-1:0]            cnt_w_q, cnt_w_d;
  logic [CW_B-1:0]            cnt_b_q, cnt_b_d;
  addr_t                      ra_w_q, ra_w_d, ra_b_q, ra_b_d;
  logic [3:0]                 vw_q, vb_q;
  logic [2:0]                 done_q;
  logic [3:0][ADDR_WIDTH-1:0] aw_q, ab_q;
  logic [DATA_N*N_LEN_W-1:0]  gw_q;
  logic [N_LEN_W-1:0]         gb_q;
  logic [DATA_N*N_LEN-1:0]    pw_q, lw, rw_q, ww_q;
  logic [N_LEN-1:0]           pb_q, lb, rb_q, wb_q;
  // issue counters and read addresses; unknown layers park the address at 0
  always_comb begin
    ok      = state_ok(state_i);
    base_w  = base_addr(state_i, W);
    base_b  = base_addr(state_i, B);
    last_w  = base_w + addr_t'(W - 1);
    last_b  = base_b + addr_t'(B - 1);
    cnt_w_d = !run_i ? '0 : cnt_w_q == CW_W'(W) ? cnt_w_q : cnt_w_q + CW_W'(1);
    cnt_b_d = !run_i ? '0 : cnt_b_q == CW_B'(B) ? cnt_b_q : cnt_b_q + CW_B'(1);
    ra_w_d  = !run_i ? base_w : (ok && ra_w_q != last_w) ? ra_w_q + addr_t'(1) : ra_w_q;
    ra_b_d  = !run_i ? base_b : (ok && ra_b_q != last_b) ? ra_b_q + addr_t'(1) : ra_b_q;
  end
  // issue -> data -> result -> write pipeline; every stage is squashed when run drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_w_q <= '0;
      cnt_b_q <= '0;
      ra_w_q  <= '0;
      ra_b_q  <= '0;
      vw_q    <= '0;
      vb_q    <= '0;
      done_q  <= '0;
      aw_q    <= '0;
      ab_q    <= '0;
      gw_q    <= '0;
      gb_q    <= '0;
      pw_q    <= '0;
      pb_q    <= '0;
      rw_q    <= '0;
      rb_q    <= '0;
      ww_q    <= '0;
      wb_q    <= '0;
    end else begin
      cnt_w_q <= cnt_w_d;
      cnt_b_q <= cnt_b_d;
      ra_w_q  <= ra_w_d;
      ra_b_q  <= ra_b_d;
      vw_q    <= {vw_q[2:0], ok && cnt_w_q != CW_W'(W)} & {4{run_i}};
      vb_q    <= {vb_q[2:0], ok && cnt_b_q != CW_B'(B)} & {4{run_i}};
      done_q  <= {done_q[1:0], cnt_w_q == CW_W'(W)} & {3{run_i}};
      aw_q    <= {aw_q[2:0], ra_w_q};
      ab_q    <= {ab_q[2:0], ra_b_q};
      gw_q    <= ram.rdata_grad_w;
      gb_q    <= ram.rdata_grad_b;
      pw_q    <= ram.rdata_param_w;
      pb_q    <= ram.rdata_param_b;
      rw_q    <= lw;
      rb_q    <= lb;
      ww_q    <= rw_q;
      wb_q    <= rb_q;
    end
  end
  for (genvar i = 0; i < DATA_N; i++) begin : g_lane
    mix_update_lane u_lane (
      .lr_i (lr_i),
      .g_i  (gw_q[i*N_LEN_W +: N_LEN_W]),
      .w_i  (pw_q[i*N_LEN +: N_LEN]),
      .w_o  (lw[i*N_LEN +: N_LEN])
    );
  end
  mix_update_lane u_bias (
    .lr_i (lr_i),
    .g_i  (gb_q),
    .w_i  (pb_q),
    .w_o  (lb)
  );
  assign ram.raddr_grad_w  = ra_w_q;
  assign ram.raddr_param_w = ra_w_q;
  assign ram.raddr_grad_b  = ra_b_q;
  assign ram.raddr_param_b = ra_b_q;
  assign ram.waddr_grad_w  = aw_q[3];
  assign ram.waddr_param_w = aw_q[3];
  assign ram.waddr_grad_b  = ab_q[3];
  assign ram.waddr_param_b = ab_q[3];
  assign ram.we_grad_w     = vw_q[3];
  assign ram.we_param_w    = vw_q[3];
  assign ram.we_grad_b     = vb_q[3];
  assign ram.we_param_b    = vb_q[3];
  assign ram.wdata_param_w = ww_q;
  assign ram.wdata_param_b = wb_q;
  assign valid_o           = done_q[2];
endmodule

// File: tb/tb_mix_update_param.sv
// tb_mix_update_param: random and directed SGD passes checked against a bench-side RAM/arithmetic model
module tb_mix_update_param;
  import mix_update_param_pkg::*;
  localparam int MEM = 1 << ADDR_WIDTH;
  logic clk = 0, rst_n = 0, run = 0, load = 0, valid;
  logic [STATE_LEN-1:0] state = U_MIX1;
  logic [N_LEN-1:0] lr = '0;
  int n_chk = 0, n_fail = 0;
  logic [DATA_N*N_LEN_W-1:0] gmem_w [MEM], src_gw [MEM], exp_gw [MEM];
  logic [DATA_N*N_LEN-1:0]   pmem_w [MEM], src_pw [MEM], exp_pw [MEM], orig_pw [MEM];
  logic [N_LEN_W-1:0]        gmem_b [MEM], src_gb [MEM], exp_gb [MEM];
  logic [N_LEN-1:0]          pmem_b [MEM], src_pb [MEM], exp_pb [MEM];
  logic [STATE_LEN-1:0]      sts [3] = '{U_MIX1, U_MIX2, U_MIX3};
  logic [N_LEN-1:0]          lr_r;

  mix_update_param_if ram_if ();
  mix_update_param dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (run),
    .state_i (state),
    .lr_i    (lr),
    .valid_o (valid),
    .ram     (ram_if)
  );

  always #5 clk = ~clk;

  // synchronous-read RAMs with one write port each; load copies in a fresh image
  always @(posedge clk) begin
    ram_if.rdata_grad_w  <= gmem_w[ram_if.raddr_grad_w];
    ram_if.rdata_grad_b  <= gmem_b[ram_if.raddr_grad_b];
    ram_if.rdata_param_w <= pmem_w[ram_if.raddr_param_w];
    ram_if.rdata_param_b <= pmem_b[ram_if.raddr_param_b];
    if (load) begin
      gmem_w <= src_gw;
      gmem_b <= src_gb;
      pmem_w <= src_pw;
      pmem_b <= src_pb;
    end else begin
      if (ram_if.we_grad_w)  gmem_w[ram_if.waddr_grad_w]  <= '0;
      if (ram_if.we_grad_b)  gmem_b[ram_if.waddr_grad_b]  <= '0;
      if (ram_if.we_param_w) pmem_w[ram_if.waddr_param_w] <= ram_if.wdata_param_w;
      if (ram_if.we_param_b) pmem_b[ram_if.waddr_param_b] <= ram_if.wdata_param_b;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // w - floor(lr*g / 2^F), shifted value wrapped to the grad width, result clamped
  function automatic logic [N_LEN-1:0] ref_lane(input int l, input int g, input int w);
    longint p, s, d, m, den, mx;
    m   = longint'(1) << N_LEN_W;
    den = longint'(1) << F_LEN;
    mx  = (longint'(1) << (N_LEN - 1)) - 1;
    p   = longint'(l) * longint'(g);
    s   = p >= 0 ? p / den : -((-p + den - 1) / den);
    s   = ((s % m) + m) % m;
    if (s >= m / 2) s = s - m;
    d   = longint'(w) - s;
    d   = d > mx ? mx : d < -mx - 1 ? -mx - 1 : d;
    return N_LEN'(d);
  endfunction

  task automatic chk_zero(input string t);
    chk({t, "_valid"}, valid, 0);
    chk({t, "_we"}, {ram_if.we_grad_w, ram_if.we_grad_b, ram_if.we_param_w, ram_if.we_param_b}, 0);
    chk({t, "_raddr"}, {ram_if.raddr_grad_w, ram_if.raddr_grad_b, ram_if.raddr_param_w, ram_if.raddr_param_b}, 0);
    chk({t, "_waddr"}, {ram_if.waddr_grad_w, ram_if.waddr_grad_b, ram_if.waddr_param_w, ram_if.waddr_param_b}, 0);
    chk({t, "_wdata"}, {ram_if.wdata_param_w, ram_if.wdata_param_b}, 0);
  endtask

  task automatic load_mem();
    @(negedge clk);
    load = 1;
    @(negedge clk);
    load = 0;
  endtask

  task automatic fill_const(input logic [N_LEN_W-1:0] g, input logic [N_LEN-1:0] w);
    for (int a = 0; a < MEM; a++) begin
      src_gw[a] = {DATA_N{g}};
      src_pw[a] = {DATA_N{w}};
      src_gb[a] = g;
      src_pb[a] = w;
    end
  endtask

  task automatic fill_rand();
    for (int a = 0; a < MEM; a++) begin
      for (int j = 0; j < DATA_N; j++) begin
        src_gw[a][j*N_LEN_W +: N_LEN_W] = $urandom_range(0, 7) == 0 ? N_LEN_W'($urandom) : N_LEN_W'(int'($urandom_range(0, 4000)) - 2000);
        src_pw[a][j*N_LEN +: N_LEN] = N_LEN'($urandom);
      end
      src_gb[a] = $urandom_range(0, 7) == 0 ? N_LEN_W'($urandom) : N_LEN_W'(int'($urandom_range(0, 4000)) - 2000);
      src_pb[a] = N_LEN'($urandom);
    end
  endtask

  // one pass; drop > 0 lowers run so that it is sampled low at edge t0+drop
  task automatic pass(input logic [STATE_LEN-1:0] st, input logic [N_LEN-1:0] l, input int drop);
    int bw, bb, lv, kmax;
    bit ok, ew, eb;
    @(negedge clk);
    run = 0;
    state = st;
    lr = l;
    @(negedge clk);
    ok = st == U_MIX1 || st == U_MIX2 || st == U_MIX3;
    bw = st == U_MIX2 ? W : st == U_MIX3 ? 2 * W : 0;
    bb = st == U_MIX2 ? B : st == U_MIX3 ? 2 * B : 0;
    lv = int'($signed(l));
    exp_gw = gmem_w;
    exp_pw = pmem_w;
    orig_pw = pmem_w;
    exp_gb = gmem_b;
    exp_pb = pmem_b;
    if (ok) begin
      for (int i = 0; i < W; i++) begin
        for (int j = 0; j < DATA_N; j++)
          exp_pw[bw+i][j*N_LEN +: N_LEN] = ref_lane(lv, $signed(gmem_w[bw+i][j*N_LEN_W +: N_LEN_W]), $signed(pmem_w[bw+i][j*N_LEN +: N_LEN]));
        exp_gw[bw+i] = '0;
      end
      for (int i = 0; i < B; i++) begin
        exp_pb[bb+i] = ref_lane(lv, $signed(gmem_b[bb+i]), $signed(pmem_b[bb+i]));
        exp_gb[bb+i] = '0;
      end
    end
    run = 1;
    kmax = drop > 0 ? drop + 4 : W + 5;
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      if (drop == 0 || k < drop) begin
        ew = ok && k >= 3 && k <= W + 2;
        eb = ok && k >= 3 && k <= B + 2;
        chk("we_param_w", ram_if.we_param_w, ew);
        chk("we_grad_w", ram_if.we_grad_w, ew);
        chk("we_param_b", ram_if.we_param_b, eb);
        chk("we_grad_b", ram_if.we_grad_b, eb);
        if (ew) begin
          chk("waddr_param_w", ram_if.waddr_param_w, bw + k - 3);
          chk("waddr_grad_w", ram_if.waddr_grad_w, bw + k - 3);
        end
        if (eb) begin
          chk("waddr_param_b", ram_if.waddr_param_b, bb + k - 3);
          chk("waddr_grad_b", ram_if.waddr_grad_b, bb + k - 3);
        end
        chk("raddr_param_w", ram_if.raddr_param_w, ok ? bw + (k + 1 < W ? k + 1 : W - 1) : 0);
        chk("raddr_grad_w", ram_if.raddr_grad_w, ok ? bw + (k + 1 < W ? k + 1 : W - 1) : 0);
        chk("raddr_param_b", ram_if.raddr_param_b, ok ? bb + (k + 1 < B ? k + 1 : B - 1) : 0);
        chk("raddr_grad_b", ram_if.raddr_grad_b, ok ? bb + (k + 1 < B ? k + 1 : B - 1) : 0);
        chk("valid", valid, k >= W + 2);
      end else if (k > drop) begin
        chk("squash_we", {ram_if.we_grad_w, ram_if.we_grad_b, ram_if.we_param_w, ram_if.we_param_b}, 0);
      end
      if (drop > 0 && k == drop - 1) run = 0;
    end
    if (drop == 0) begin
      for (int a = 0; a < 3 * W; a++) begin
        chk("param_w", pmem_w[a], exp_pw[a]);
        chk("grad_w", gmem_w[a], exp_gw[a]);
      end
      for (int a = 0; a < 3 * B; a++) begin
        chk("param_b", pmem_b[a], exp_pb[a]);
        chk("grad_b", gmem_b[a], exp_gb[a]);
      end
      run = 0;
      @(negedge clk);
      chk("valid_fall", valid, 0);
    end else begin
      for (int a = 0; a < 3 * W; a++)
        chk("partial_w", pmem_w[a] === orig_pw[a] || pmem_w[a] === exp_pw[a], 1'b1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    fill_const(24'd256, 16'd512);
    load_mem();
    pass(U_MIX2, 16'd256, 0);
    chk("mix2_w_val", pmem_w[W+7], {DATA_N{16'd256}});
    chk("mix2_w_last", pmem_w[2*W-1], {DATA_N{16'd256}});
    chk("mix2_b_val", pmem_b[B+3], 16'd256);
    chk("mix1_untouched", pmem_w[3], {DATA_N{16'd512}});
    chk("mix2_grad_clear", gmem_w[2*W-1], 0);
    fill_const('0, '0);
    src_gw[0] = {24'(8388607), 24'(-8388607), 24'sd3, -24'sd3};
    src_pw[0] = {16'h8000, 16'h7fff, 16'd100, 16'd100};
    src_gb[0] = -24'sd3;
    src_pb[0] = 16'd100;
    load_mem();
    pass(U_MIX1, 16'd128, 0);
    chk("floor_neg", pmem_w[0][15:0], 16'd102);
    chk("floor_pos", pmem_w[0][31:16], 16'd99);
    chk("sat_pos", pmem_w[0][47:32], 16'h7fff);
    chk("sat_neg", pmem_w[0][63:48], 16'h8000);
    chk("bias_floor", pmem_b[0], 16'd102);
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      load_mem();
      lr_r = $urandom_range(0, 3) == 0 ? N_LEN'($urandom) : N_LEN'(int'($urandom_range(0, 1024)) - 512);
      pass(sts[$urandom_range(0, 2)], lr_r, 0);
    end
    fill_rand();
    load_mem();
    pass(3'd0, 16'd256, 0);
    pass(3'd7, 16'd200, 0);
    fill_rand();
    load_mem();
    lr_r = N_LEN'(int'($urandom_range(0, 1024)) - 512);
    pass(U_MIX2, lr_r, 10);
    pass(U_MIX2, lr_r, 0);
    fill_rand();
    load_mem();
    @(negedge clk);
    state = U_MIX3;
    lr = 16'd300;
    @(negedge clk);
    run = 1;
    repeat (6) @(negedge clk);
    rst_n = 0;
    #1;
    chk_zero("rst_mid");
    run = 0;
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1;
    pass(U_MIX3, 16'd300, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
